// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with a runtime modulus (0..max_val), sync clear/load,
// wrap or saturate at the limits, and registered carry/borrow event pulses.
module updown_counter_param #(
  parameter int               WIDTH     = 4,
  parameter bit               SATURATE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] cnt_nxt;
  logic             carry_nxt;
  logic             borrow_nxt;

  // ">=" rather than "==" so a modulus lowered beneath the current count
  // still counts as being at the limit.
  assign at_max = (count >= max_val);
  assign at_min = (count == '0);

  always_comb begin
    cnt_nxt    = count;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = (din > max_val) ? max_val : din;
    end else if (up) begin
      if (at_max) begin
        carry_nxt = 1'b1;
        cnt_nxt   = SATURATE ? max_val : '0;
      end else begin
        cnt_nxt = count + WIDTH'(1);
      end
    end else if (down) begin
      if (at_min) begin
        borrow_nxt = 1'b1;
        cnt_nxt    = SATURATE ? '0 : max_val;
      end else begin
        cnt_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= RESET_VAL;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      count  <= cnt_nxt;
      carry  <= carry_nxt;
      borrow <= borrow_nxt;
    end
  end

endmodule
